// File: rtl/cycle_report_tx.sv
// Sends a 4-byte cycle report (count hi/lo, accumulator hi/lo) on each rising edge of halt; first start 1 cycle after the edge.
// Backpressure: each byte waits indefinitely for i_tx_done before the next start.
module cycle_report_tx #(
    parameter int CONTADOR_LENGTH = 11,
    parameter int ACC_LENGTH      = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_halt,
    input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
    input  logic [ACC_LENGTH-1:0]      i_acumulador,
    input  logic                       i_tx_done,
    output logic                       o_tx_start,
    output logic [DATA_BITS-1:0]       o_data,
    output logic                       o_busy,
    output logic                       o_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   h_prev_q, h_prev_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            acc_q, acc_d;
    logic [1:0]             idx_q, idx_d;
    logic                   tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   halt_rise;

    function automatic logic [7:0] pick_byte(input logic [1:0] idx,
                                             input logic [15:0] cnt,
                                             input logic [15:0] acc);
        logic [7:0] b;
        case (idx)
            2'd0:    b = cnt[15:8];
            2'd1:    b = cnt[7:0];
            2'd2:    b = acc[15:8];
            default: b = acc[7:0];
        endcase
        return b;
    endfunction

    assign halt_rise = i_halt & ~h_prev_q;

    always_comb begin
        state_d    = state_q;
        h_prev_d   = i_halt;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (halt_rise) begin
                    cnt_d      = 16'(i_cuenta);
                    acc_d      = 16'(i_acumulador);
                    idx_d      = 2'd0;
                    data_d     = DATA_BITS'(pick_byte(2'd0, 16'(i_cuenta), 16'(i_acumulador)));
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            // Any i_tx_done here belongs to the previous byte and is dropped.
            SEND: state_d = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        data_d     = DATA_BITS'(pick_byte(idx_q + 2'd1, cnt_q, acc_q));
                        tx_start_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!i_halt) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // h_prev resets high so a halt already asserted at reset release is not an edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            h_prev_q   <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_prev_q   <= h_prev_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: doc/cycle_report_tx.md
CYCLE_REPORT_TX -- requirements
Module: cycle_report_tx

Interface
REQ-001 Parameter CONTADOR_LENGTH, default 11, width of the cycle count input; SHALL be constrained to 1..16.
REQ-002 Parameter ACC_LENGTH, default 16, width of the accumulator input; SHALL be constrained to 1..16.
REQ-003 Parameter DATA_BITS, default 8, width of the byte bus to the UART transmitter.
REQ-004 i_clock  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_reset  input  1  synchronous reset, active-high.
REQ-006 i_halt  input  1  CPU halt level; a rising edge requests one report.
REQ-007 i_cuenta  input  CONTADOR_LENGTH  live cycle count from the cycle counter.
REQ-008 i_acumulador  input  ACC_LENGTH  live CPU accumulator value.
REQ-009 i_tx_done  input  1  one-cycle pulse from the UART transmitter: current byte finished.
REQ-010 o_tx_start  output  1  one-cycle pulse: transmit o_data.
REQ-011 o_data  output  DATA_BITS  byte to transmit, registered.
REQ-012 o_busy  output  1  high while a report is in progress.
REQ-013 o_done  output  1  high after all bytes have been sent, until i_halt falls.

Function
REQ-014 FSM states SHALL be IDLE, SEND, WAIT, DONE; all outputs SHALL be registered.
REQ-015 Halt edge detect: a registered copy h_prev of i_halt; the rising edge is i_halt=1 and h_prev=0.
REQ-016 IDLE + rising edge at edge k: latch i_cuenta and i_acumulador, zero-extended to 16 bits each; byte index := 0; go to SEND; o_tx_start=1 and o_data=byte0 in cycle k+1.
REQ-017 Byte order SHALL be cnt[15:8], cnt[7:0], acc[15:8], acc[7:0], for 4 bytes total.
REQ-018 SEND lasts exactly one cycle (o_tx_start=1), then WAIT (o_tx_start=0); i_tx_done SHALL be ignored in SEND.
REQ-019 WAIT + i_tx_done=1 with index<3: index+1, o_data:=next byte, o_tx_start=1 in the next cycle (state SEND).
REQ-020 WAIT + i_tx_done=1 with index=3: go to DONE; o_busy:=0, o_done:=1.
REQ-021 o_data SHALL stay stable from its o_tx_start pulse until the next o_tx_start.
REQ-022 o_busy SHALL be 1 in SEND and WAIT, and 0 in IDLE and DONE.
REQ-023 DONE: stay while i_halt=1; when i_halt=0, go to IDLE with o_done:=0.
REQ-024 Halt edges arriving in SEND, WAIT or DONE SHALL be ignored, with no re-latch and no queueing.
REQ-025 i_tx_done in IDLE or DONE SHALL be ignored.
REQ-026 Latched values SHALL NOT change during a report, even though i_cuenta keeps counting.
REQ-027 The module SHALL have no timeout; WAIT holds indefinitely until i_tx_done.

Reset
REQ-028 i_reset=1 at a rising edge: state IDLE, o_tx_start=0, o_data=0, o_busy=0, o_done=0, index=0, latches=0.
REQ-029 Reset SHALL set h_prev=1, so a halt held high through reset release does not start a report.
REQ-030 Reset SHALL take priority over all other inputs; reset mid-report SHALL abort with no further o_tx_start.

Verification
REQ-031 Basic report: i_cuenta=11'h5A3, i_acumulador=16'h1234, i_halt 0->1, with i_tx_done 10 cycles after each start -> o_data sequence 0x05, 0xA3, 0x12, 0x34, exactly 4 start pulses, then o_done=1 and o_busy=0.
REQ-032 Count extremes: i_cuenta=11'h7FF changing every cycle after the trigger, i_acumulador=16'hFFFF -> bytes 0x07, 0xFF, 0xFF, 0xFF, all from the value latched at the trigger.
REQ-033 Back-to-back i_tx_done: i_tx_done asserted in the first WAIT cycle each time -> start pulses exactly 2 cycles apart; an i_tx_done coinciding with o_tx_start has no effect.
REQ-034 Reset mid-report: i_reset after byte 1 is sent -> next cycle all outputs 0; i_halt still high -> no new report; i_halt 0->1 afterwards -> full 4-byte report.
REQ-035 Spurious inputs: i_tx_done pulses in IDLE, and a second i_halt edge during WAIT -> no extra o_tx_start; exactly one 4-byte report; DONE exits only after i_halt=0.
